// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO for the EX stage.
// Long ops compute into a shadow pair at acceptance and commit to HI/LO after a fixed latency.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   shi_q, shi_d;
    logic [31:0]   slo_q, slo_d;

    logic [63:0]        prod_u;
    logic signed [63:0] prod_s;
    logic               div_signed;
    logic               a_neg, b_neg;
    logic [31:0]        a_mag, b_mag, b_safe;
    logic [31:0]        q_mag, r_mag, quot, rem;
    logic               commit, accept;

    assign prod_u = {32'b0, a} * {32'b0, b};
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

    // Sign-magnitude division: truncates toward zero and gives the remainder the
    // dividend's sign; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign div_signed = ~op[0];
    assign a_neg      = div_signed & a[31];
    assign b_neg      = div_signed & b[31];
    assign a_mag      = a_neg ? (~a + 32'd1) : a;
    assign b_mag      = b_neg ? (~b + 32'd1) : b;
    assign b_safe     = (b == 32'd0) ? 32'd1 : b_mag;
    assign q_mag      = a_mag / b_safe;
    assign r_mag      = a_mag % b_safe;
    assign quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem        = a_neg ? (~r_mag + 32'd1) : r_mag;

    assign commit = (state_q == S_RUN) && (cnt_q == '0);
    assign accept = start && ((state_q == S_IDLE) || commit);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        shi_d   = shi_q;
        slo_d   = slo_q;

        if (state_q == S_RUN) begin
            if (commit) begin
                hi_d    = shi_q;
                lo_d    = slo_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        // A request landing on the commit edge sees the just-committed HI/LO.
        if (accept) begin
            case (op)
                3'd0, 3'd1: begin
                    {shi_d, slo_d} = op[0] ? prod_u : prod_s;
                    cnt_d          = CW'(MULT_CYCLES - 1);
                    busy_d         = 1'b1;
                    state_d        = S_RUN;
                end
                3'd2, 3'd3: begin
                    if (b == 32'd0) begin
                        shi_d = hi_d;
                        slo_d = lo_d;
                    end else begin
                        shi_d = rem;
                        slo_d = quot;
                    end
                    cnt_d   = CW'(DIV_CYCLES - 1);
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
                3'd4:    hi_d = a;
                3'd5:    lo_d = a;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            shi_q   <= '0;
            slo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            shi_q   <= shi_d;
            slo_q   <= slo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule
